// File: rtl/bcd_alu_pkg.sv
// Shared definitions for the sequential signed-BCD calculator ALU:
// operation codes, controller states and the all-nines result pattern.
package bcd_alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_SCALE,
    S_EXEC,
    S_CHECK,
    S_TOBCD
  } state_t;

  // BCD pattern with the lowest 'digits' nibbles set to 9 (up to 9 digits).
  // Callers slice the width they need.
  function automatic logic [35:0] all_nines(input int unsigned digits);
    logic [35:0] v;
    v = '0;
    for (int i = 0; i < 9; i++) begin
      if (i < digits) v[i*4 +: 4] = 4'h9;
    end
    return v;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Serial double-dabble converter: one bit per cycle, BIN_W cycles after load.
// 'done' pulses for one cycle once 'bcd' holds the converted value; 'bcd'
// then stays stable until the next load.
module bin2bcd_seq #(
  parameter int BIN_W     = 27,
  parameter int DIGIT_NUM = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [BIN_W-1:0]       bin,
  output logic                   busy,
  output logic                   done,
  output logic [DIGIT_NUM*4-1:0] bcd
);

  localparam int DW    = DIGIT_NUM * 4;
  localparam int CNT_W = $clog2(BIN_W + 1);

  logic [BIN_W-1:0] sh;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]    adj;

  // Add-3 correction on every digit that would exceed 9 after the next shift.
  always_comb begin
    // NOTE: assigning a default before any conditional update keeps this
    // purely combinational; a path that leaves it unassigned infers a latch.
    adj = bcd;
    for (int i = 0; i < DIGIT_NUM; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
  end

  // Shift register and bit counter; done is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      sh   <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      bcd  <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        sh   <= bin;
        bcd  <= '0;
        cnt  <= CNT_W'(BIN_W);
        busy <= 1'b1;
      end else if (busy) begin
        bcd <= {adj[DW-2:0], sh[BIN_W-1]};
        sh  <= {sh[BIN_W-2:0], 1'b0};
        cnt <= cnt - 1'b1;
        if (cnt == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_alu_seq.sv
// Multi-cycle signed-BCD calculator ALU with decimal-point alignment.
// Flow: IDLE -> CONV (BCD->binary, Horner) -> SCALE (dp alignment) -> EXEC
// (add/sub 1 cycle, shift-add mul, restoring div) -> CHECK (overflow/error)
// -> TOBCD (serial double-dabble) -> IDLE with a one-cycle done pulse.
// Define BCD_ALU_DIV_EN to build the divider; without it op 3 is illegal.
module bcd_alu_seq
  import bcd_alu_pkg::*;
#(
  parameter int DIGIT_NUM = 8,
  parameter int DP_W      = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   ready,
  input  logic [2:0]             operation,
  input  logic                   op0_sign,
  input  logic                   op1_sign,
  input  logic [DIGIT_NUM*4-1:0] op0,
  input  logic [DIGIT_NUM*4-1:0] op1,
  input  logic [DP_W-1:0]        op0_dp,
  input  logic [DP_W-1:0]        op1_dp,
  output logic                   done,
  output logic [DIGIT_NUM*4-1:0] result,
  output logic                   result_sign,
  output logic [DP_W-1:0]        result_dp,
  output logic                   overflow,
  output logic                   error
);

  localparam int unsigned LIMIT_I = 10 ** DIGIT_NUM;
  localparam int BIN_W = $clog2(LIMIT_I);
  localparam int W     = 2 * BIN_W;
  localparam int DW    = DIGIT_NUM * 4;
  localparam int CNT_W = $clog2(W + 1);

  localparam logic [W-1:0]  LIMIT     = W'(LIMIT_I);
  localparam logic [35:0]   NINES_ALL = all_nines(DIGIT_NUM);
  localparam logic [DW-1:0] NINES     = NINES_ALL[DW-1:0];

  state_t state, state_nx;

  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_r;
  logic             s0_r, s1_r;
  logic [DW-1:0]    d0_r, d1_r;
  logic [DP_W-1:0]  dp0_r, dp1_r;
  logic [W-1:0]     m0, m1, mag;
  logic             sign_r, in_err;
  logic             err_r, ovf_r, sign_f;

  logic             op_legal, is_div;
  logic             scale_m0;
  logic [DP_W-1:0]  scale_n;
  logic [DP_W:0]    dp_calc;
  logic [CNT_W-1:0] exec_len;
  logic [3:0]       dig0, dig1;
  logic             s1_eff, as_sign;
  logic [W-1:0]     as_mag;
  logic [W-1:0]     fin_mag;
  logic             chk_err, chk_ovf, chk_sign;

  logic             conv_load, conv_busy, conv_done;
  logic [DW-1:0]    bcd;

`ifdef BCD_ALU_DIV_EN
  logic [W-1:0] rem, rem_diff;
  logic [W:0]   rem_sh;
  logic         rem_ge;

  assign op_legal = (op_r <= OP_DIV);
  assign is_div   = (op_r == OP_DIV);

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh   = {rem, m0[W-1]};
    rem_ge   = (rem_sh >= {1'b0, m1});
    rem_diff = rem_sh[W-1:0] - m1;
  end
`else
  assign op_legal = (op_r <= OP_MUL);
  assign is_div   = 1'b0;
`endif

  assign ready     = (state == S_IDLE) && !conv_busy;
  assign conv_load = (state == S_CHECK);
  assign dig0      = d0_r[DW-1 -: 4];
  assign dig1      = d1_r[DW-1 -: 4];

  // Alignment plan: which operand is scaled, for how many cycles, and the result dp.
  always_comb begin
    scale_m0 = 1'b0;
    scale_n  = '0;
    dp_calc  = '0;
    exec_len = CNT_W'(1);
    if (op_r == OP_ADD || op_r == OP_SUB) begin
      if (dp0_r < dp1_r) begin
        scale_m0 = 1'b1;
        scale_n  = dp1_r - dp0_r;
        dp_calc  = {1'b0, dp1_r};
      end else begin
        scale_n  = dp0_r - dp1_r;
        dp_calc  = {1'b0, dp0_r};
      end
    end else if (op_r == OP_MUL) begin
      dp_calc  = {1'b0, dp0_r} + {1'b0, dp1_r};
      exec_len = CNT_W'(BIN_W);
    end else if (is_div) begin
      scale_m0 = 1'b1;
      scale_n  = dp1_r;
      dp_calc  = {1'b0, dp0_r};
      exec_len = CNT_W'(W);
    end
  end

  // Signed-magnitude add/sub: the larger magnitude decides the sign.
  always_comb begin
    s1_eff  = s1_r ^ (op_r == OP_SUB);
    as_mag  = m0 + m1;
    as_sign = s0_r;
    if (s0_r != s1_eff) begin
      if (m0 >= m1) begin
        as_mag  = m0 - m1;
        as_sign = s0_r;
      end else begin
        as_mag  = m1 - m0;
        as_sign = s1_eff;
      end
    end
  end

  // Result classification; error beats overflow, and an erroneous or zero
  // result is never reported as negative.
  always_comb begin
    fin_mag  = is_div ? m0 : mag;
    chk_err  = in_err || !op_legal || (is_div && (m1 == '0));
    chk_ovf  = !chk_err && ((fin_mag >= LIMIT) || ((op_r == OP_MUL) && dp_calc[DP_W]));
    chk_sign = !chk_err && (fin_mag != '0) && sign_r;
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; the shared counter times every multi-cycle phase.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_CONV;
      S_CONV:  if (cnt == CNT_W'(DIGIT_NUM - 1))
                 state_nx = (scale_n != '0) ? S_SCALE : S_EXEC;
      S_SCALE: if (cnt == CNT_W'(1)) state_nx = S_EXEC;
      S_EXEC:  if (cnt == CNT_W'(1)) state_nx = S_CHECK;
      S_CHECK: state_nx = S_TOBCD;
      S_TOBCD: if (conv_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Datapath, phase counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      op_r        <= '0;
      s0_r        <= 1'b0;
      s1_r        <= 1'b0;
      d0_r        <= '0;
      d1_r        <= '0;
      dp0_r       <= '0;
      dp1_r       <= '0;
      m0          <= '0;
      m1          <= '0;
      mag         <= '0;
      sign_r      <= 1'b0;
      in_err      <= 1'b0;
      err_r       <= 1'b0;
      ovf_r       <= 1'b0;
      sign_f      <= 1'b0;
`ifdef BCD_ALU_DIV_EN
      rem         <= '0;
`endif
      done        <= 1'b0;
      result      <= '0;
      result_sign <= 1'b0;
      result_dp   <= '0;
      overflow    <= 1'b0;
      error       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_r   <= operation;
            s0_r   <= op0_sign;
            s1_r   <= op1_sign;
            d0_r   <= op0;
            d1_r   <= op1;
            dp0_r  <= op0_dp;
            dp1_r  <= op1_dp;
            m0     <= '0;
            m1     <= '0;
            mag    <= '0;
            sign_r <= 1'b0;
            in_err <= 1'b0;
            cnt    <= '0;
`ifdef BCD_ALU_DIV_EN
            rem    <= '0;
`endif
          end
        end
        S_CONV: begin
          m0   <= m0 * W'(10) + W'(dig0);
          m1   <= m1 * W'(10) + W'(dig1);
          d0_r <= d0_r << 4;
          d1_r <= d1_r << 4;
          if (dig0 > 4'd9 || dig1 > 4'd9) in_err <= 1'b1;
          if (cnt == CNT_W'(DIGIT_NUM - 1))
            cnt <= (scale_n != '0) ? CNT_W'(scale_n) : exec_len;
          else
            cnt <= cnt + 1'b1;
        end
        S_SCALE: begin
          if (scale_m0) m0 <= m0 * W'(10);
          else          m1 <= m1 * W'(10);
          cnt <= (cnt == CNT_W'(1)) ? exec_len : cnt - 1'b1;
        end
        S_EXEC: begin
          cnt <= cnt - 1'b1;
          if (op_r == OP_MUL) begin
            if (m1[0]) mag <= mag + m0;
            m0     <= m0 << 1;
            m1     <= m1 >> 1;
            sign_r <= s0_r ^ s1_r;
          end
`ifdef BCD_ALU_DIV_EN
          else if (is_div) begin
            rem    <= rem_ge ? rem_diff : rem_sh[W-1:0];
            m0     <= {m0[W-2:0], rem_ge};
            sign_r <= s0_r ^ s1_r;
          end
`endif
          else begin
            mag    <= as_mag;
            sign_r <= as_sign;
          end
        end
        S_CHECK: begin
          err_r  <= chk_err;
          ovf_r  <= chk_ovf;
          sign_f <= chk_sign;
        end
        S_TOBCD: begin
          if (conv_done) begin
            done        <= 1'b1;
            result      <= (err_r || ovf_r) ? NINES : bcd;
            result_sign <= sign_f;
            result_dp   <= dp_calc[DP_W-1:0];
            overflow    <= ovf_r;
            error       <= err_r;
          end
        end
        default: ;
      endcase
    end
  end

  // Conversion always runs so latency does not depend on the outcome.
  bin2bcd_seq #(
    .BIN_W     (BIN_W),
    .DIGIT_NUM (DIGIT_NUM)
  ) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (conv_load),
    .bin   (fin_mag[BIN_W-1:0]),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

endmodule

// File: tb/tb_bcd_alu_seq.sv
// Scoreboard bench for bcd_alu_seq (DIGIT_NUM=8, DP_W=3): directed vectors push
// expected results and latencies; a monitor pops and compares on every done.
module tb_bcd_alu_seq;
  import bcd_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  operation = '0;
  logic        op0_sign = 1'b0, op1_sign = 1'b0;
  logic [31:0] op0 = '0, op1 = '0;
  logic [2:0]  op0_dp = '0, op1_dp = '0;
  logic        ready, done, result_sign, overflow, error;
  logic [31:0] result;
  logic [2:0]  result_dp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_expected = 0;
  int n_done = 0;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        sign;
    logic [2:0]  dp;
    logic        ovf;
    logic        err;
    int          lat;
    int          t0;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  bcd_alu_seq #(.DIGIT_NUM(8), .DP_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .ready       (ready),
    .operation   (operation),
    .op0_sign    (op0_sign),
    .op1_sign    (op1_sign),
    .op0         (op0),
    .op1         (op1),
    .op0_dp      (op0_dp),
    .op1_dp      (op1_dp),
    .done        (done),
    .result      (result),
    .result_sign (result_sign),
    .result_dp   (result_dp),
    .overflow    (overflow),
    .error       (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_result"}, 64'(result), 64'(mon_e.res));
        check({mon_e.name, "_sign"}, 64'(result_sign), 64'(mon_e.sign));
        check({mon_e.name, "_dp"}, 64'(result_dp), 64'(mon_e.dp));
        check({mon_e.name, "_overflow"}, 64'(overflow), 64'(mon_e.ovf));
        check({mon_e.name, "_error"}, 64'(error), 64'(mon_e.err));
        check({mon_e.name, "_latency"}, 64'(cyc - mon_e.t0), 64'(mon_e.lat));
        check({mon_e.name, "_ready"}, 64'(ready), 64'd1);
      end
    end
  end

  // Issue one operation once ready, and record what the monitor should see.
  task automatic issue(input string name, input logic [2:0] op,
                       input logic s0, input logic [31:0] a, input logic [2:0] adp,
                       input logic s1, input logic [31:0] b, input logic [2:0] bdp,
                       input logic [31:0] res, input logic rs, input logic [2:0] rdp,
                       input logic ovf, input logic err, input int lat);
    exp_t e;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) check({name, "_ready_timeout"}, 64'd0, 64'd1);
    operation = op;
    op0_sign  = s0;
    op0       = a;
    op0_dp    = adp;
    op1_sign  = s1;
    op1       = b;
    op1_dp    = bdp;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    e.name = name;
    e.res  = res;
    e.sign = rs;
    e.dp   = rdp;
    e.ovf  = ovf;
    e.err  = err;
    e.lat  = lat;
    e.t0   = cyc;
    exp_q.push_back(e);
    n_expected++;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_sign", 64'(result_sign), 64'd0);
    check("rst_dp", 64'(result_dp), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    rst_n = 1'b1;

    // add/sub, alignment and sign handling
    issue("add_12p5_3p75", OP_ADD, 0, 32'h125, 1, 0, 32'h375, 2, 32'h1625, 0, 2, 0, 0, 39);
    issue("sub_5_12",      OP_SUB, 0, 32'h5,   0, 0, 32'h12,  0, 32'h7,    1, 0, 0, 0, 38);
    issue("add_neg",       OP_ADD, 1, 32'h3,   0, 1, 32'h4,   0, 32'h7,    1, 0, 0, 0, 38);
    issue("sub_1p00_2p5",  OP_SUB, 0, 32'h100, 2, 0, 32'h25,  1, 32'h150,  1, 2, 0, 0, 39);
    issue("sub_to_zero",   OP_SUB, 1, 32'h5,   0, 1, 32'h5,   0, 32'h0,    0, 0, 0, 0, 38);
    issue("add_ovf", OP_ADD, 0, 32'h99999999, 0, 0, 32'h1, 0, 32'h99999999, 0, 0, 1, 0, 38);

    // multiply
    issue("mul_neg0",   OP_MUL, 1, 32'h0,  0, 0, 32'h5, 0, 32'h0,  0, 0, 0, 0, 64);
    issue("mul_ovf", OP_MUL, 0, 32'h99999999, 0, 0, 32'h2, 0, 32'h99999999, 0, 0, 1, 0, 64);
    issue("mul_m1p5_2", OP_MUL, 1, 32'h15, 1, 0, 32'h2, 0, 32'h30, 1, 1, 0, 0, 64);
    issue("mul_dp_ovf", OP_MUL, 0, 32'h1,  7, 0, 32'h1, 1, 32'h99999999, 0, 0, 1, 0, 64);

    // divide
`ifdef BCD_ALU_DIV_EN
    issue("div_10_4",    OP_DIV, 0, 32'h1000, 2, 0, 32'h4, 0, 32'h250, 0, 2, 0, 0, 91);
    issue("div_7_0",     OP_DIV, 0, 32'h7,    0, 0, 32'h0, 0, 32'h99999999, 0, 0, 0, 1, 91);
    issue("div_1p5_0p5", OP_DIV, 0, 32'h15,   1, 0, 32'h5, 1, 32'h30,  0, 1, 0, 0, 92);
    issue("div_m7_2",    OP_DIV, 1, 32'h7,    0, 0, 32'h2, 0, 32'h3,   1, 0, 0, 0, 91);
    issue("div_m1_4",    OP_DIV, 1, 32'h1,    0, 0, 32'h4, 0, 32'h0,   0, 0, 0, 0, 91);
`else
    issue("div_disabled", OP_DIV, 0, 32'h1000, 2, 0, 32'h4, 0, 32'h99999999, 0, 0, 0, 1, 38);
`endif

    // input and opcode errors
    issue("bad_digit", OP_ADD, 0, 32'h1A, 0, 0, 32'h1, 0, 32'h99999999, 0, 0, 0, 1, 38);
    issue("bad_op",    3'd5,   0, 32'h12, 0, 0, 32'h3, 0, 32'h99999999, 0, 0, 0, 1, 38);

    // start while busy is ignored
    issue("busy_add", OP_ADD, 0, 32'h2, 0, 0, 32'h3, 0, 32'h5, 0, 0, 0, 0, 38);
    @(negedge clk);
    @(negedge clk);
    check("busy_ready_low", 64'(ready), 64'd0);
    operation = OP_MUL;
    op0       = 32'h9;
    op1       = 32'h9;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    drain();

    // reset mid-operation aborts without a done
    issue("aborted", OP_ADD, 0, 32'h1, 0, 0, 32'h1, 0, 32'h2, 0, 0, 0, 0, 38);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    n_expected -= exp_q.size();
    exp_q.delete();
    #1;
    check("abort_ready", 64'(ready), 64'd1);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_sign", 64'(result_sign), 64'd0);
    check("abort_dp", 64'(result_dp), 64'd0);
    check("abort_overflow", 64'(overflow), 64'd0);
    check("abort_error", 64'(error), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);

    // normal operation after the abort
    issue("post_reset_mul", OP_MUL, 0, 32'h12, 0, 0, 32'h12, 0, 32'h144, 0, 0, 0, 0, 64);
    drain();
    check("done_count", 64'(n_done), 64'(n_expected));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_alu_seq.md
# bcd_alu_seq

Multi-cycle, parametrised signed-BCD calculator ALU with decimal-point alignment, overflow and error reporting, and a start/done handshake. Sits between the keypad/entry logic and the display driver. Converts both BCD operands to binary serially, aligns decimal points, executes add/sub/mul/div, and converts the result back to BCD with a serial double-dabble. Successor to the combinational calculator ALU: one operation in flight, variable latency.

## Interface
- DIGIT_NUM, 8, BCD digits per operand/result (2..9)
- DP_W, 3, decimal-point index width; dp counts digits right of the point
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when ready=1
- ready  out  1  block idle, can accept start
- operation  in  3  0 add, 1 sub, 2 mul, 3 div, 4..7 illegal
- op0_sign / op1_sign  in  1  1 = negative
- op0 / op1  in  DIGIT_NUM*4  BCD magnitudes, digit 0 in [3:0]
- op0_dp / op1_dp  in  DP_W  decimal-point position
- done  out  1  one-cycle pulse, result valid
- result  out  DIGIT_NUM*4  BCD magnitude
- result_sign  out  1  1 = negative, never set for zero
- result_dp  out  DP_W  result decimal-point position
- overflow  out  1  magnitude or dp not representable
- error  out  1  divide by zero, illegal op, or non-BCD input digit

## Operation
- Constants: BIN_W = clog2(10^DIGIT_NUM) (27 for 8); datapath W = 2*BIN_W.
- States: IDLE -> CONV -> SCALE -> EXEC -> CHECK -> TOBCD -> IDLE.
- IDLE: ready=1. On start, register all inputs, go CONV. start while ready=0 ignored.
- CONV: Horner (acc = acc*10 + digit), MSD first, both operands in parallel, DIGIT_NUM cycles. Any digit >9 latches input error.
- SCALE: add/sub: smaller-dp operand multiplied by 10 per cycle, |dp0-dp1| cycles, result_dp = max(dp0,dp1). div: m0 multiplied by 10, dp1 cycles, result_dp = dp0. mul: 0 cycles, result_dp = dp0+dp1 computed in DP_W+1 bits.
- EXEC: add/sub signed-magnitude (compare, add or subtract, sign of larger), 1 cycle. mul shift-add, BIN_W cycles, sign = s0^s1. div restoring, W cycles, quotient truncated toward zero, sign = s0^s1.
- CHECK (1 cycle): overflow if magnitude >= 10^DIGIT_NUM or mul dp > 2^DP_W-1. error conditions: m1=0 on div, operation>3, input error. On overflow or error result forced to all-9s BCD; error has priority, overflow cleared when error set. Zero magnitude forces sign 0.
- TOBCD: double-dabble over BIN_W bits, BIN_W cycles, always run (uniform latency).
- Outputs registered; loaded with done, held until next accepted start.

## Timing
- Reset: ready=1, done=0, result=0, result_sign=0, result_dp=0, overflow=0, error=0, state IDLE.
- Cycle 0 = edge accepting start. ready drops at cycle 1.
- done at cycle L = DIGIT_NUM + n + E + BIN_W + 2, n = SCALE cycles, E = 1 (add/sub/illegal), BIN_W (mul), W (div). ready=1 same cycle as done.
- start sampled with done high is accepted (back-to-back).
- rst_n low mid-operation: immediate return to reset values; no done for aborted op.

## Configuration
- BCD_ALU_DIV_EN defined: divider and div scaling present, op 3 as above.
- Not defined: divider removed; op 3 treated as illegal (error=1, all-9s, E=1).

## Structure
- Package bcd_alu_pkg: op codes (OP_ADD..OP_DIV), state enum, all-9s pattern function of DIGIT_NUM.
- Sub-module bin2bcd_seq: serial double-dabble, load/busy/done, parametrised by BIN_W and DIGIT_NUM.

## Test plan
- add 12.5 (0x00000125 dp1) + 3.75 (0x00000375 dp2) -> 0x00001625 dp2 sign0, done at cycle 8+1+1+27+2=39.
- sub 5 - 12 (dp0) -> 0x00000007 sign1 dp0, overflow=0, error=0; -0 * 5 -> 0x00000000 sign0.
- mul 99999999 * 2 -> overflow=1, result 0x99999999; mul -1.5 (15 dp1 sign1) * 2 -> 0x00000030 dp1 sign1.
- div 10.00 (0x00001000 dp2) / 4 -> 0x00000250 dp2; div 7 / 0 -> error=1, 0x99999999; with macro undefined op 3 -> error=1.
- op0 digit 0xA or operation=5 -> error=1, overflow=0, result 0x99999999.
- start pulsed during busy ignored (single done); rst_n low at cycle 10 -> all outputs 0, ready=1, no done.
